// File: rtl/qracc_pkg.sv
// Shared QR-ACC types and defaults: SRAM phase sequencer state and phase lengths.
package qracc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PCH,
    S_WL,
    S_SENSE,
    S_RDONE
  } qracc_sram_seq_state_t;

  localparam int SRAM_PCH_CYCLES = 1;
  localparam int SRAM_WL_CYCLES  = 1;
  localparam int SRAM_SA_CYCLES  = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qracc_sram_rw_seq.sv
// Expands one SRAM word request into registered precharge / wordline / write / sense phases
// on the analog macro and returns the sensed word as a one-cycle rd_valid_o pulse.
module qracc_sram_rw_seq
  import qracc_pkg::*;
#(
  parameter int numRows   = 128,
  parameter int numCols   = 32,
  parameter int pchCycles = SRAM_PCH_CYCLES,
  parameter int wlCycles  = SRAM_WL_CYCLES,
  parameter int saCycles  = SRAM_SA_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       analog_lock_i,
  input  logic                       rq_wr_i,
  input  logic                       rq_valid_i,
  output logic                       rq_ready_o,
  input  logic [numCols-1:0]         wr_data_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  output logic [numRows-1:0]         WL,
  output logic                       PCH,
  output logic                       WRITE,
  output logic [numCols-1:0]         WR_DATA,
  output logic [numCols-1:0]         CSEL,
  output logic                       SAEN,
  input  logic [numCols-1:0]         SA_OUT
);

  localparam int AW = $clog2(numRows);
  localparam int CW = $clog2(max3(pchCycles, wlCycles, saCycles) + 1);

  qracc_sram_seq_state_t state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               wr_q, wr_n;
  logic [AW-1:0]      addr_q, addr_n;
  logic [numCols-1:0] data_q, data_n;
  logic [numRows-1:0] wl_dec;
  logic               accept, wl_on, wr_on;

  assign rq_ready_o = (state == S_IDLE) && !analog_lock_i && !rst;
  assign accept     = rq_valid_i && rq_ready_o;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: if (accept) begin
        state_n = S_PCH;
        cnt_n   = '0;
      end
      S_PCH: if (cnt == CW'(pchCycles - 1)) begin
        state_n = S_WL;
        cnt_n   = '0;
      end else cnt_n = cnt + CW'(1);
      S_WL: if (cnt == CW'(wlCycles - 1)) begin
        state_n = wr_q ? S_IDLE : S_SENSE;
        cnt_n   = '0;
      end else cnt_n = cnt + CW'(1);
      S_SENSE: if (cnt == CW'(saCycles - 1)) begin
        state_n = S_RDONE;
        cnt_n   = '0;
      end else cnt_n = cnt + CW'(1);
      S_RDONE: state_n = S_IDLE;
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Analog controls are registered from the next state so each phase starts on a clean edge,
  // including the accept edge where the request fields are still on the inputs.
  always_comb begin
    wr_n   = accept ? rq_wr_i   : wr_q;
    addr_n = accept ? addr_i    : addr_q;
    data_n = accept ? wr_data_i : data_q;
    wl_on  = (state_n == S_WL) || (state_n == S_SENSE);
    wr_on  = (state_n == S_WL) && wr_n;
    wl_dec = '0;
    // Rows past numRows never match, so an out-of-range address drives no wordline.
    for (int i = 0; i < numRows; i++) wl_dec[i] = (addr_n == AW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      PCH        <= 1'b0;
      WL         <= '0;
      CSEL       <= '0;
      WRITE      <= 1'b0;
      WR_DATA    <= '0;
      SAEN       <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      wr_q       <= wr_n;
      addr_q     <= addr_n;
      data_q     <= data_n;
      PCH        <= (state_n == S_PCH);
      WL         <= wl_on ? wl_dec : '0;
      CSEL       <= wl_on ? '1 : '0;
      WRITE      <= wr_on;
      WR_DATA    <= wr_on ? data_n : '0;
      SAEN       <= (state_n == S_SENSE);
      rd_valid_o <= (state_n == S_RDONE);
      if (state == S_SENSE && state_n == S_RDONE) rd_data_o <= SA_OUT;
    end
  end

endmodule

// File: tb/tb_qracc_sram_rw_seq.sv
// Directed bench for qracc_sram_rw_seq: default-timing instance plus a 2/3/2-phase instance.
module tb_qracc_sram_rw_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] ONE    = 128'd1;
  localparam logic [31:0]  ONES32 = 32'hFFFF_FFFF;

  // default instance
  logic         rst, lock, rq_wr, rq_valid, rq_ready, rd_valid, pch, write, saen;
  logic [31:0]  wr_data, rd_data, wdat, csel, sa_out, sa_drv, sa_model;
  logic [6:0]   addr;
  logic [127:0] wl;
  logic         sa_model_en;

  // 2/3/2 instance
  logic         lock2, wr2, valid2, ready2, rdv2, pch2, write2, saen2;
  logic [31:0]  wdata2, rdd2, wdat2, csel2, sa2;
  logic [6:0]   addr2;
  logic [127:0] wl2;

  qracc_sram_rw_seq dut (
    .clk(clk), .rst(rst), .analog_lock_i(lock), .rq_wr_i(rq_wr), .rq_valid_i(rq_valid),
    .rq_ready_o(rq_ready), .wr_data_i(wr_data), .addr_i(addr), .rd_valid_o(rd_valid),
    .rd_data_o(rd_data), .WL(wl), .PCH(pch), .WRITE(write), .WR_DATA(wdat), .CSEL(csel),
    .SAEN(saen), .SA_OUT(sa_out)
  );

  qracc_sram_rw_seq #(.pchCycles(2), .wlCycles(3), .saCycles(2)) dut2 (
    .clk(clk), .rst(rst), .analog_lock_i(lock2), .rq_wr_i(wr2), .rq_valid_i(valid2),
    .rq_ready_o(ready2), .wr_data_i(wdata2), .addr_i(addr2), .rd_valid_o(rdv2),
    .rd_data_o(rdd2), .WL(wl2), .PCH(pch2), .WRITE(write2), .WR_DATA(wdat2), .CSEL(csel2),
    .SAEN(saen2), .SA_OUT(sa2)
  );

  function automatic logic [196:0] mk(input logic p, input logic [127:0] w, input logic wr,
                                      input logic [31:0] wd, input logic [31:0] cs,
                                      input logic sa, input logic rv, input logic rr);
    return {p, w, wr, wd, cs, sa, rv, rr};
  endfunction

  logic [196:0] obs, obs2;
  assign obs  = mk(pch, wl, write, wdat, csel, saen, rd_valid, rq_ready);
  assign obs2 = mk(pch2, wl2, write2, wdat2, csel2, saen2, rdv2, ready2);

  // analog array model: stores what the DUT drives, answers sense cycles
  logic [31:0] arr [128];
  always @(posedge clk)
    if (write) for (int i = 0; i < 128; i++) if (wl[i]) arr[i] <= wdat;
  always_comb begin
    sa_model = 32'h5A5A_5A5A;
    if (saen) for (int i = 0; i < 128; i++) if (wl[i]) sa_model = arr[i];
  end
  assign sa_out = sa_model_en ? sa_model : sa_drv;

  logic mon_en = 1'b0;
  int   onehot_bad = 0;
  always @(negedge clk) if (mon_en && $countones(wl) > 1) onehot_bad++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; lock = 1'b0; rq_valid = 1'b0; rq_wr = 1'b0; addr = '0; wr_data = '0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({obs, rd_data} !== '0) begin
      errors++; $display("FAIL reset_state: got %h want 0", {obs, rd_data});
    end
    tick(); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rq_ready); end
    tick(); lock = 1'b1;
    @(negedge clk);
    checks++;
    if (rq_ready !== 1'b0) begin errors++; $display("FAIL reset_locked_ready: got %b want 0", rq_ready); end
    tick(); lock = 1'b0;
  endtask

  task automatic test_write();
    logic [196:0] e;
    rq_wr = 1'b1; addr = 7'd5; wr_data = 32'hDEAD_BEEF; rq_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (rq_ready !== 1'b1) begin errors++; $display("FAIL write_c0_ready: got %b want 1", rq_ready); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) rq_valid = 1'b0;
      @(negedge clk);
      case (c)
        1:       e = mk(1, 0, 0, 0, 0, 0, 0, 0);
        2:       e = mk(0, ONE << 5, 1, 32'hDEAD_BEEF, ONES32, 0, 0, 0);
        default: e = mk(0, 0, 0, 0, 0, 0, 0, 1);
      endcase
      checks++;
      if (obs !== e) begin errors++; $display("FAIL write_c%0d: got %h want %h", c, obs, e); end
    end
  endtask

  task automatic test_read();
    logic [196:0] e;
    logic [31:0]  er;
    tick();
    rq_wr = 1'b0; addr = 7'd5; rq_valid = 1'b1; sa_drv = 32'h1234_5678;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) rq_valid = 1'b0;
      sa_drv = (c == 3) ? 32'hDEAD_BEEF : 32'h1234_5678;
      @(negedge clk);
      case (c)
        1:       e = mk(1, 0, 0, 0, 0, 0, 0, 0);
        2:       e = mk(0, ONE << 5, 0, 0, ONES32, 0, 0, 0);
        3:       e = mk(0, ONE << 5, 0, 0, ONES32, 1, 0, 0);
        4:       e = mk(0, 0, 0, 0, 0, 0, 1, 0);
        default: e = mk(0, 0, 0, 0, 0, 0, 0, 1);
      endcase
      er = (c >= 4) ? 32'hDEAD_BEEF : 32'h0;
      checks++;
      if ({obs, rd_data} !== {e, er})
        begin errors++; $display("FAIL read_c%0d: got %h/%h want %h/%h", c, obs, rd_data, e, er); end
    end
  endtask

  task automatic test_long_read();
    logic [196:0] e;
    logic         wlon;
    tick();
    wr2 = 1'b0; addr2 = 7'd127; valid2 = 1'b1; sa2 = 32'h0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) valid2 = 1'b0;
      sa2 = (c == 7) ? 32'hA5A5_5A5A : 32'h0;
      @(negedge clk);
      wlon = (c >= 3 && c <= 7);
      e = mk(c <= 2, wlon ? ONE << 127 : 128'd0, 0, 0, wlon ? ONES32 : 32'h0,
             c >= 6 && c <= 7, c == 8, c == 9);
      checks++;
      if (obs2 !== e) begin errors++; $display("FAIL long_read_c%0d: got %h want %h", c, obs2, e); end
    end
    checks++;
    if (rdd2 !== 32'hA5A5_5A5A) begin errors++; $display("FAIL long_read_data: got %h want a5a55a5a", rdd2); end
  endtask

  task automatic test_lock();
    logic [196:0] e;
    tick();
    lock = 1'b1; rq_wr = 1'b0; addr = 7'd3; rq_valid = 1'b1; sa_drv = 32'h3333_3333;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL lock_hold_c%0d: got %h want 0", c, obs); end
      tick();
    end
    lock = 1'b0;
    @(negedge clk);
    checks++;
    if (rq_ready !== 1'b1) begin errors++; $display("FAIL lock_release_ready: got %b want 1", rq_ready); end
    // lock rises again mid-sequence: the read still completes, the next accept is blocked
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) rq_valid = 1'b0;
      if (c == 2) lock = 1'b1;
      @(negedge clk);
      case (c)
        1:       e = mk(1, 0, 0, 0, 0, 0, 0, 0);
        2:       e = mk(0, ONE << 3, 0, 0, ONES32, 0, 0, 0);
        3:       e = mk(0, ONE << 3, 0, 0, ONES32, 1, 0, 0);
        4:       e = mk(0, 0, 0, 0, 0, 0, 1, 0);
        default: e = mk(0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      checks++;
      if (obs !== e) begin errors++; $display("FAIL lock_seq_c%0d: got %h want %h", c, obs, e); end
    end
    checks++;
    if (rd_data !== 32'h3333_3333) begin errors++; $display("FAIL lock_data: got %h want 33333333", rd_data); end
    tick(); lock = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [196:0] e;
    int rv_seen;
    rq_wr = 1'b0; addr = 7'd9; rq_valid = 1'b1; sa_drv = 32'h7777_7777;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) rq_valid = 1'b0;
    end
    @(negedge clk);
    e = mk(0, ONE << 9, 0, 0, ONES32, 1, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL rstmid_sense: got %h want %h", obs, e); end
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({obs, rd_data} !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h want 0", {obs, rd_data}); end
    rst = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      if (rd_valid) rv_seen++;
    end
    checks++;
    if (rv_seen != 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d pulses want 0", rv_seen); end
    tick();
    addr = 7'd9; rq_valid = 1'b1; sa_drv = 32'h0BAD_F00D;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) rq_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_data} !== {1'b1, 32'h0BAD_F00D})
      begin errors++; $display("FAIL rstmid_reread: got %b/%h want 1/0badf00d", rd_valid, rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sb [128];
    int n;
    int a;
    tick();
    sa_model_en = 1'b1; mon_en = 1'b1;
    for (int r = 0; r < 128; r++) begin
      rq_wr = 1'b1; addr = 7'(r); wr_data = $urandom; sb[r] = wr_data; rq_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!rq_ready && n < 20);
      if (n >= 20) begin
        checks++; errors++; $display("FAIL b2b_write_timeout: row %0d no ready in 20 cycles", r);
      end
      tick();
    end
    for (int r = 0; r < 128; r++) begin
      a = (r * 37) % 128;
      rq_wr = 1'b0; addr = 7'(a); rq_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!rq_ready && n < 20);
      tick();
      n = 0;
      do begin @(negedge clk); n++; end while (!rd_valid && n < 10);
      checks++;
      if (!rd_valid || rd_data !== sb[a]) begin
        errors++; $display("FAIL b2b_read row %0d: got %b/%h want 1/%h", a, rd_valid, rd_data, sb[a]);
      end
      tick();
    end
    rq_valid = 1'b0; mon_en = 1'b0;
    checks++;
    if (onehot_bad != 0) begin errors++; $display("FAIL b2b_wl_onehot: got %0d bad cycles want 0", onehot_bad); end
    sa_model_en = 1'b0;
  endtask

  initial begin
    sa_model_en = 1'b0; sa_drv = '0;
    lock2 = 1'b0; wr2 = 1'b0; valid2 = 1'b0; wdata2 = '0; addr2 = '0; sa2 = '0;
    test_reset();
    test_write();
    test_read();
    test_long_read();
    test_lock();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/qracc_sram_rw_seq.md
# qracc_sram_rw_seq

Phase sequencer between the digital SRAM request port and the analog SRAM macro. Accepts one word read/write request at a time over the `sram_itf` slave handshake and expands it into timed precharge, wordline, write-drive and sense-amp phases on the SRAM subset of `to_analog_t`. It returns sensed data from `SA_OUT` as a `rd_valid_o` pulse. It sits directly downstream of the SRAM request fields defined in `qracc_pkg` and upstream of the analog column array. While analog MAC compute owns the array, it is locked out.

## Interface
- `numRows`, default 128, number of wordlines
- `numCols`, default 32, word width in bits
- `pchCycles`, default 1, precharge phase length in cycles, ≥1
- `wlCycles`, default 1, wordline/write phase length in cycles, ≥1
- `saCycles`, default 1, sense phase length in cycles, ≥1
- `clk` input 1: single clock; all logic on the rising edge
- `rst` input 1: reset, synchronous, active-high
- `analog_lock_i` input 1: analog compute owns the array; blocks new requests
- `rq_wr_i` input 1: 1 = write, 0 = read
- `rq_valid_i` input 1: request valid
- `rq_ready_o` output 1: request accepted on the edge where valid and ready are both 1
- `wr_data_i` input numCols: write word
- `addr_i` input $clog2(numRows): row address
- `rd_valid_o` output 1: one-cycle pulse; `rd_data_o` is valid
- `rd_data_o` output numCols: last sensed word
- `WL` output numRows: one-hot wordline
- `PCH` output 1: bitline precharge, active-high
- `WRITE` output 1: write drivers enabled
- `WR_DATA` output numCols: write drive data
- `CSEL` output numCols: column select
- `SAEN` output 1: sense-amp enable
- `SA_OUT` input numCols: sense-amp outputs

## Operation
- FSM states: S_IDLE, S_PCH, S_WL, S_SENSE, S_RDONE.
- S_IDLE: `rq_ready_o` = !`analog_lock_i`. On accept, latch `rq_wr_i`/`addr_i`/`wr_data_i`, clear the phase counter, then go to S_PCH.
- S_PCH: `PCH`=1 for pchCycles cycles, then go to S_WL.
- S_WL: `WL[addr]`=1 and `CSEL`=all ones for wlCycles cycles.
  - On a write, `WRITE`=1 and `WR_DATA`=latched data.
  - On completion, a write goes to S_IDLE and a read goes to S_SENSE.
- S_SENSE: `WL[addr]` stays 1, `SAEN`=1 for saCycles cycles. On the last cycle, capture `SA_OUT` into `rd_data_o`, then go to S_RDONE.
- S_RDONE: `rd_valid_o`=1 for one cycle, then go to S_IDLE.
- `rd_data_o` holds its value until the next read capture.
- All analog controls are registered and glitch-free; at most one of PCH/WL-phase/SAEN is active.
- `WR_DATA` is 0 outside write WL phases. `WL` and `CSEL` are 0 outside S_WL/S_SENSE.
- Out-of-range `addr_i` (≥numRows) is accepted and sequenced with all `WL`=0. A read then returns whatever `SA_OUT` carries.
- `analog_lock_i` rising mid-sequence does not abort the sequence; it only blocks the next accept.
- Phase counter width is $clog2(max(pchCycles,wlCycles,saCycles)+1) and it saturates at no value beyond the phase length.

## Timing
- Reset values: `rq_ready_o`=0, `rd_valid_o`=0, `rd_data_o`=0, `WL`=0, `PCH`=0, `WRITE`=0, `WR_DATA`=0, `CSEL`=0, `SAEN`=0. FSM is in S_IDLE.
- The first cycle after `rst` deasserts: `rq_ready_o`=!`analog_lock_i`.
- Accept edge = cycle 0. `PCH` is high in cycles 1..P, with P=pchCycles.
- `WL` is high in cycles P+1..P+W, with W=wlCycles.
- Write: `rq_ready_o` is high again in cycle P+W+1.
- Read: `SAEN` is high in cycles P+W+1..P+W+S, with S=saCycles. `SA_OUT` is sampled at the end of cycle P+W+S.
  - `rd_valid_o` is high in cycle P+W+S+1; `rq_ready_o` is high in cycle P+W+S+2.
  - With defaults: read latency is 4 cycles to `rd_valid_o`; write occupancy is 2 cycles.
- `rq_ready_o` is 0 in every non-IDLE state. There is no back-to-back accept and no queuing.
- `rq_valid_i` held with `analog_lock_i`=1 is not accepted. Accept occurs in the first IDLE cycle in which the lock is low.
- `rst` mid-sequence: next cycle all outputs return to their reset values. The aborted read produces no `rd_valid_o`.

## Structure
- Add a `qracc_sram_seq_state_t` enum and default phase-length constants (`SRAM_PCH_CYCLES`, `SRAM_WL_CYCLES`, `SRAM_SA_CYCLES`) to `qracc_pkg`.
- The module exposes the request side through an `sram_itf.slave` modport wrapper at integration; the core uses flat ports.
- No sub-module: a single FSM plus one shared phase counter.

## Test plan
- Reset, then write addr 5 with data 0xDEADBEEF (defaults) → `PCH` high at cycle 1; `WL[5]`, `WRITE`=1, `WR_DATA`=0xDEADBEEF at cycle 2; `rq_ready_o`=1 at cycle 3.
- Read addr 5 with `SA_OUT`=0xDEADBEEF (defaults) → `SAEN` at cycle 3, `rd_valid_o` pulse at cycle 4, `rd_data_o`=0xDEADBEEF held afterward.
- pchCycles=2, wlCycles=3, saCycles=2, read addr 127 → `PCH` in cycles 1–2, `WL[127]` in cycles 3–7, `SAEN` in cycles 6–7, `rd_valid_o` in cycle 8.
- `analog_lock_i`=1 with `rq_valid_i` held for 10 cycles → `rq_ready_o`=0 and no analog activity. Lock drops → accepted next cycle.
- `rst` asserted in cycle 3 of a read (`SAEN` phase) → all outputs 0 next cycle, no `rd_valid_o`. A new read after reset completes normally.
- Randomised back-to-back writes then reads over all rows against a scoreboard memory model driving `SA_OUT` → every `rd_data_o` matches; `WL` is always one-hot or zero.
